// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble sequencer for the 5-stage pipeline.
// Define PERF_CNT_EN to get saturating stall and flush event counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_DmemREB,
    input  logic        EX_PCsel,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    output logic        CNTEN,
    output logic        IFID_EN,
    output logic        IFID_FLUSH,
    output logic        IDEX_EN,
    output logic        IDEX_BUBBLE,
    output logic        EXMEM_EN,
    output logic        MEMWB_EN,
    output logic [2:0]  STATE,
    output logic        MEM_ERR,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
);

    typedef enum logic [2:0] {
        sIdle    = 3'd0,
        sRun     = 3'd1,
        sMemWait = 3'd2,
        sFlush   = 3'd3,
        sHalt    = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT     = 8'(MEM_TIMEOUT);
    localparam logic [1:0] FLUSH_EXTRA = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     state;
    state_t     nextState;
    state_t     advNext;
    logic [7:0] waitCnt;
    logic [7:0] nextWait;
    logic [1:0] flushRem;
    logic [1:0] nextFlushRem;
    logic [1:0] advFlushRem;
    logic       memErr;
    logic       nextErr;
    logic       loadUse;
    logic       memStall;
    logic       advCnt;
    logic       advIfidEn;
    logic       advFlush;
    logic       advBubble;

    assign loadUse = ~EX_DmemREB & (EX_rd != 5'd0)
                   & ((ID_uses_rs1 & (ID_rs1 == EX_rd))
                   |  (ID_uses_rs2 & (ID_rs2 == EX_rd)));
    assign memStall = MEM_req & ~MEM_ready;

    assign STATE   = state;
    assign MEM_ERR = memErr;

    // Decode of a cycle in which the pipe advances: squash beats load-use stall
    always_comb begin
        advCnt      = 1'b1;
        advIfidEn   = 1'b1;
        advFlush    = 1'b0;
        advBubble   = 1'b0;
        advFlushRem = flushRem;
        advNext     = sIdle;
        if (EX_PCsel) begin
            advFlush  = 1'b1;
            advBubble = 1'b1;
            if (MULTI_FLUSH) advFlushRem = FLUSH_EXTRA;
        end else if (loadUse) begin
            advCnt    = 1'b0;
            advIfidEn = 1'b0;
            advBubble = 1'b1;
        end
        if (advFlushRem != 2'd0) advNext = sFlush;
        else if (RUN)            advNext = sRun;
        else                     advNext = sIdle;
    end

    // Next-state and pipeline control decode
    always_comb begin
        CNTEN        = 1'b0;
        IFID_EN      = 1'b0;
        IFID_FLUSH   = 1'b0;
        IDEX_EN      = 1'b0;
        IDEX_BUBBLE  = 1'b0;
        EXMEM_EN     = 1'b0;
        MEMWB_EN     = 1'b0;
        nextState    = state;
        nextWait     = waitCnt;
        nextFlushRem = flushRem;
        nextErr      = memErr;
        unique case (state)
            sIdle: begin
                if (RUN) nextState = sRun;
            end
            sRun: begin
                if (memStall) begin
                    nextState = sMemWait;
                    nextWait  = 8'd1;
                end else begin
                    CNTEN        = advCnt;
                    IFID_EN      = advIfidEn;
                    IFID_FLUSH   = advFlush;
                    IDEX_EN      = 1'b1;
                    IDEX_BUBBLE  = advBubble;
                    EXMEM_EN     = 1'b1;
                    MEMWB_EN     = 1'b1;
                    nextState    = advNext;
                    nextFlushRem = advFlushRem;
                end
            end
            sMemWait: begin
                if (MEM_ready) begin
                    CNTEN        = advCnt;
                    IFID_EN      = advIfidEn;
                    IFID_FLUSH   = advFlush;
                    IDEX_EN      = 1'b1;
                    IDEX_BUBBLE  = advBubble;
                    EXMEM_EN     = 1'b1;
                    MEMWB_EN     = 1'b1;
                    nextState    = advNext;
                    nextFlushRem = advFlushRem;
                    nextWait     = 8'd0;
                end else if (waitCnt >= TIMEOUT) begin
                    nextState = sHalt;
                    nextErr   = 1'b1;
                end else begin
                    nextWait = waitCnt + 8'd1;
                end
            end
            sFlush: begin
                if (memStall) begin
                    nextState = sMemWait;
                    nextWait  = 8'd1;
                end else begin
                    CNTEN        = 1'b1;
                    IFID_EN      = 1'b1;
                    IFID_FLUSH   = 1'b1;
                    IDEX_EN      = 1'b1;
                    IDEX_BUBBLE  = 1'b1;
                    EXMEM_EN     = 1'b1;
                    MEMWB_EN     = 1'b1;
                    nextFlushRem = flushRem - 2'd1;
                    if (flushRem <= 2'd1) nextState = sRun;
                end
            end
            sHalt: begin
                nextState = sHalt;
            end
            default: begin
                nextState = sIdle;
            end
        endcase
    end

    // State, wait counter, pending flush count and sticky error
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= sIdle;
            waitCnt  <= 8'd0;
            flushRem <= 2'd0;
            memErr   <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWait;
            flushRem <= nextFlushRem;
            memErr   <= nextErr;
        end
    end

`ifdef PERF_CNT_EN
    logic        stallCycle;
    logic        pcAccept;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    assign stallCycle = ~CNTEN & ((state == sRun) | (state == sMemWait)
                      | (state == sFlush));
    assign pcAccept   = EX_PCsel & (((state == sRun) & ~memStall)
                      | ((state == sMemWait) & MEM_ready));

    // Saturating stall-cycle and accepted-redirect counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stallCnt <= 32'd0;
            flushCnt <= 32'd0;
        end else begin
            if (stallCycle && stallCnt != 32'hFFFF_FFFF)
                stallCnt <= stallCnt + 32'd1;
            if (pcAccept && flushCnt != 32'hFFFF_FFFF)
                flushCnt <= flushCnt + 32'd1;
        end
    end

    assign STALL_CNT = stallCnt;
    assign FLUSH_CNT = flushCnt;
`else
    assign STALL_CNT = 32'd0;
    assign FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Directed hazard sequences followed by randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 15;
    localparam int FCY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RST, RUN;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd;
    logic        ID_uses_rs1, ID_uses_rs2;
    logic        EX_DmemREB, EX_PCsel, MEM_req, MEM_ready;
    logic        CNTEN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_BUBBLE;
    logic        EXMEM_EN, MEMWB_EN, MEM_ERR;
    logic [2:0]  STATE;
    logic [31:0] STALL_CNT, FLUSH_CNT;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .FLUSH_CYCLES(FCY)) dut (
        .CLK(clk), .RST(RST), .RUN(RUN),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_DmemREB(EX_DmemREB), .EX_PCsel(EX_PCsel),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .CNTEN(CNTEN), .IFID_EN(IFID_EN), .IFID_FLUSH(IFID_FLUSH),
        .IDEX_EN(IDEX_EN), .IDEX_BUBBLE(IDEX_BUBBLE),
        .EXMEM_EN(EXMEM_EN), .MEMWB_EN(MEMWB_EN),
        .STATE(STATE), .MEM_ERR(MEM_ERR),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    typedef struct packed {
        logic       rst, run;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exRd;
        logic       reb, pcs, memReq, memReady;
    } stim_t;

    typedef struct packed {
        logic        cnten, ifidEn, ifidFlush, idexEn, idexBubble;
        logic        exmemEn, memwbEn;
        logic [2:0]  state;
        logic        memErr;
        logic [31:0] stall, flush;
    } exp_t;

    exp_t  expQ[$];
    exp_t  mExp, got;
    stim_t s;
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;

    // Reference model: running/waiting/flushing/halted as independent facts
    bit          mActive = 0, mHalted = 0, mErr = 0;
    int          mWait = 0, mFlushLeft = 0;
    logic [31:0] mStall = 0, mFlushN = 0;

    task automatic applyStim();
        RST = s.rst; RUN = s.run;
        ID_rs1 = s.rs1; ID_rs2 = s.rs2;
        ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2;
        EX_rd = s.exRd; EX_DmemREB = s.reb; EX_PCsel = s.pcs;
        MEM_req = s.memReq; MEM_ready = s.memReady;
    endtask

    task automatic clearStim();
        s = '0;
        s.reb = 1'b1;
        s.run = 1'b1;
    endtask

    task automatic drive();
        exp_t e;
        int   st;
        bit   lu, ms, adv;
        @(posedge clk);
        #1;
        applyStim();
        lu = !s.reb && s.exRd != 0
             && ((s.u1 && s.rs1 == s.exRd) || (s.u2 && s.rs2 == s.exRd));
        ms = s.memReq && !s.memReady;
        if (mHalted)              st = 4;
        else if (mWait > 0)       st = 2;
        else if (!mActive)        st = 0;
        else if (mFlushLeft > 0)  st = 3;
        else                      st = 1;
        e = '0;
        e.state  = 3'(st);
        e.memErr = mErr;
`ifdef PERF_CNT_EN
        e.stall = mStall;
        e.flush = mFlushN;
`endif
        adv = 0;
        if (mHalted) begin
        end else if (!mActive) begin
            mActive = s.run;
        end else if (mWait > 0) begin
            if (s.memReady) begin
                adv = 1;
                mWait = 0;
            end else if (mWait >= TMO) begin
                mHalted = 1;
                mErr = 1;
            end else begin
                mWait++;
            end
        end else if (ms) begin
            mWait = 1;
        end else if (mFlushLeft > 0) begin
            e.cnten = 1; e.ifidEn = 1; e.ifidFlush = 1;
            e.idexEn = 1; e.idexBubble = 1;
            e.exmemEn = 1; e.memwbEn = 1;
            mFlushLeft--;
        end else begin
            adv = 1;
        end
        if (adv) begin
            e.cnten = 1; e.ifidEn = 1; e.idexEn = 1;
            e.exmemEn = 1; e.memwbEn = 1;
            if (s.pcs) begin
                e.ifidFlush = 1;
                e.idexBubble = 1;
                if (mFlushN != 32'hFFFF_FFFF) mFlushN++;
                mFlushLeft = FCY - 1;
            end else if (lu) begin
                e.cnten = 0;
                e.ifidEn = 0;
                e.idexBubble = 1;
            end
            if (mFlushLeft == 0) mActive = s.run;
        end
        if (st >= 1 && st <= 3 && !e.cnten && mStall != 32'hFFFF_FFFF)
            mStall++;
        expQ.push_back(e);
        if (s.rst) begin
            mActive = 0; mHalted = 0; mErr = 0;
            mWait = 0; mFlushLeft = 0;
            mStall = 0; mFlushN = 0;
        end
    endtask

    // Monitor: every cycle the DUT presents a control word; pop and compare
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mExp = expQ.pop_front();
            got = {CNTEN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_BUBBLE,
                   EXMEM_EN, MEMWB_EN, STATE, MEM_ERR, STALL_CNT, FLUSH_CNT};
            checks++;
            if (got === mExp) passes++;
            else $display("FAIL cyc%0d ctrl got %h exp %h", cyc, got, mExp);
            cyc++;
        end
    end

    initial begin
        int  budget;
        bit  slow;
        clearStim();
        s.rst = 1'b1;
        s.run = 1'b0;
        applyStim();
        @(posedge clk);
        drive();
        drive();
        s.rst = 1'b0;
        drive();
        s.run = 1'b1;
        drive();
        drive();

        // load-use stall, then rd=x0 which must not stall
        s.reb = 0; s.exRd = 5; s.rs1 = 5; s.u1 = 1;
        drive();
        clearStim(); drive();
        s.reb = 0; s.exRd = 0; s.rs1 = 0; s.u1 = 1;
        drive();
        clearStim(); drive();

        // redirect coinciding with load-use
        s.reb = 0; s.exRd = 7; s.rs2 = 7; s.u2 = 1; s.pcs = 1;
        drive();
        clearStim(); drive(); drive();

        // four-cycle memory wait
        s.memReq = 1;
        repeat (4) drive();
        s.memReady = 1;
        drive();
        clearStim(); drive();

        // reset in the middle of a memory wait
        s.memReq = 1;
        repeat (3) drive();
        s.rst = 1;
        drive();
        clearStim(); drive(); drive();

        // RUN dropped during a memory wait
        s.memReq = 1;
        drive();
        s.run = 0;
        repeat (3) drive();
        s.memReady = 1;
        drive();
        s.memReq = 0; s.memReady = 0;
        drive();
        s.run = 1;
        drive(); drive();

        // watchdog timeout with RUN toggling, then recovery by reset
        s.memReq = 1;
        repeat (20) begin
            s.run = 1'($urandom_range(0, 1));
            drive();
        end
        clearStim(); s.rst = 1;
        drive();
        clearStim(); drive(); drive();

        // randomized traffic
        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) slow = ($urandom_range(0, 3) == 0);
            s.rst      = ($urandom_range(0, 199) == 0);
            s.run      = ($urandom_range(0, 9) != 0);
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs2      = 5'($urandom_range(0, 3));
            s.exRd     = 5'($urandom_range(0, 3));
            s.u1       = 1'($urandom_range(0, 1));
            s.u2       = 1'($urandom_range(0, 1));
            s.reb      = 1'($urandom_range(0, 1));
            s.pcs      = ($urandom_range(0, 7) == 0);
            s.memReq   = ($urandom_range(0, 2) == 0);
            s.memReady = slow ? ($urandom_range(0, 19) == 0)
                              : 1'($urandom_range(0, 1));
            drive();
        end

        budget = 10;
        while (expQ.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (expQ.size() > 0) begin
            checks++;
            $display("FAIL drain pending %0d required 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
